// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and the fetch queue entry layout.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam int          FQ_DEPTH  = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch -> queue -> decode signal bundle; the queue itself uses the slave modport.
interface fetch_queue_if import cpu_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
);

  // Handshake: a push happens on a rising edge where in_valid && in_ready,
  // a pop where out_valid && out_ready. in_ready/out_valid never depend on
  // in_valid/out_ready; flush overrides both transfers in the same cycle.
  logic             in_valid;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic             out_ready;
  logic             flush;
  logic [PTR_W:0]   level;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, level
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, level
  );

endinterface

// File: rtl/fq_ptr.sv
// Wrapping PTR_W-bit pointer with increment enable; clear wins over increment.
module fq_ptr #(
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [PTR_W-1:0] o_ptr
);

  logic [PTR_W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetch and decode with flush on redirect.
module fetch_queue import cpu_pkg::*; #(
  parameter int DEPTH = FQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W:0]   r_count;
  logic [PTR_W-1:0] w_wr_ptr;
  logic [PTR_W-1:0] w_rd_ptr;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  fq_entry_t        w_head;

  // Full/empty come from count only, so pointer equality is never ambiguous.
  assign w_in_ready  = (r_count != FULL_CNT);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  fq_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_push),
    .i_clr (bus.flush),
    .o_ptr (w_wr_ptr)
  );

  fq_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_pop),
    .i_clr (bus.flush),
    .o_ptr (w_rd_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (bus.flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable while count covers them.
  always_ff @(posedge clk) begin
    if (w_push && !bus.flush) begin
      r_mem[w_wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
  end

  assign w_head        = r_mem[w_rd_ptr];
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_valid ? w_head.instr : NOP_INSTR;
  assign bus.out_pc    = w_out_valid ? w_head.pc    : 32'h0000_0000;
  assign bus.level     = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  logic [63:0] exp_q[$];   // {pc, instr}, oldest first
  int n_cmp;
  int n_err;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_pc();
    logic [63:0] e;
    if (exp_q.size() == 0) return 32'h0;
    e = exp_q[0];
    return e[63:32];
  endfunction

  function automatic logic [31:0] exp_instr();
    logic [63:0] e;
    if (exp_q.size() == 0) return 32'h0;
    e = exp_q[0];
    return e[31:0];
  endfunction

  // One clock of stimulus; the model applies the queue rules at the edge.
  task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    bit m_push, m_pop;
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    bus.flush     = fl;
    m_push = v && (exp_q.size() < DEPTH);
    m_pop  = rdy && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    else begin
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) exp_q.push_back({pc, instr});
    end
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (exp_q.size() > 0) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'hdead_beef; bus.in_pc = 32'h3000;
    bus.out_ready = 1'b1; bus.flush = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); end
    n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc: got %h want 0", bus.out_pc); end
    @(negedge clk);
    reset = 1'b1;
    // Flush at the first edge after release drops the pending push.
    cycle(1'b1, 32'hdead_beef, 32'h3000, 1'b0, 1'b1);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL release_flush_valid: got %b want 0", bus.out_valid); end
    idle();
    n_cmp++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL release_level: got %0d want 0", bus.level); end
  endtask

  task automatic test_single_push();
    cycle(1'b1, 32'h3c01_1234, 32'h3000, 1'b0, 1'b0);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
    n_cmp++; if (bus.out_pc !== 32'h3000) begin n_err++; $display("FAIL single_pc: got %h want 3000", bus.out_pc); end
    n_cmp++; if (bus.out_instr !== 32'h3c01_1234) begin n_err++; $display("FAIL single_instr: got %h want 3c011234", bus.out_instr); end
    n_cmp++; if (bus.level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", bus.level); end
    drain();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_fill_full();
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h1000_0000 + k, 32'h3000 + 4*k, 1'b0, 1'b0);
    n_cmp++; if (bus.level !== 3'd4) begin n_err++; $display("FAIL full_level: got %0d want 4", bus.level); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    cycle(1'b1, 32'h1000_0004, 32'h3010, 1'b0, 1'b0);
    n_cmp++; if (bus.level !== 3'd4) begin n_err++; $display("FAIL full_fifth_ignored: got %0d want 4", bus.level); end
    n_cmp++; if (bus.out_pc !== 32'h3000) begin n_err++; $display("FAIL full_head: got %h want 3000", bus.out_pc); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.out_pc !== 32'h3000 + 4*k) begin n_err++; $display("FAIL drain_order_%0d: got %h want %h", k, bus.out_pc, 32'h3000 + 4*k); end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", bus.out_valid); end
    // A pop while full must not let a same-cycle push in.
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'h2000_0000 + k, 32'h3100 + 4*k, 1'b0, 1'b0);
    cycle(1'b1, 32'h2000_0009, 32'h3200, 1'b1, 1'b0);
    n_cmp++; if (bus.level !== 3'd3) begin n_err++; $display("FAIL full_pop_no_pass: got %0d want 3", bus.level); end
    for (int k = 1; k < 4; k++) begin
      n_cmp++; if (bus.out_pc !== 32'h3100 + 4*k) begin n_err++; $display("FAIL full_pop_order_%0d: got %h want %h", k, bus.out_pc, 32'h3100 + 4*k); end
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_stream_wrap();
    cycle(1'b1, 32'h5000_0000, 32'h3000, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      n_cmp++; if (bus.out_pc !== 32'h3000 + 4*(k-1)) begin n_err++; $display("FAIL stream_pc_%0d: got %h want %h", k, bus.out_pc, 32'h3000 + 4*(k-1)); end
      cycle(1'b1, 32'h5000_0000 + k, 32'h3000 + 4*k, 1'b1, 1'b0);
      n_cmp++; if (bus.level !== 3'd1) begin n_err++; $display("FAIL stream_level_%0d: got %0d want 1", k, bus.level); end
    end
    n_cmp++; if (bus.out_instr !== 32'h5000_000a) begin n_err++; $display("FAIL stream_last_instr: got %h want 5000000a", bus.out_instr); end
    drain();
  endtask

  task automatic test_flush_collision();
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'h6000_0000 + k, 32'h3000 + 4*k, 1'b0, 1'b0);
    n_cmp++; if (bus.level !== 3'd3) begin n_err++; $display("FAIL flush_pre_level: got %0d want 3", bus.level); end
    cycle(1'b1, 32'h6000_0020, 32'h3020, 1'b1, 1'b1);
    n_cmp++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL flush_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    cycle(1'b1, 32'h6000_0040, 32'h3040, 1'b0, 1'b0);
    n_cmp++; if (bus.out_pc !== 32'h3040) begin n_err++; $display("FAIL flush_next_pc: got %h want 3040", bus.out_pc); end
    n_cmp++; if (bus.level !== 3'd1) begin n_err++; $display("FAIL flush_next_level: got %0d want 1", bus.level); end
    drain();
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 2; k++) cycle(1'b1, 32'h7000_0000 + k, 32'h3000 + 4*k, 1'b0, 1'b0);
    n_cmp++; if (bus.level !== 3'd2) begin n_err++; $display("FAIL async_pre_level: got %0d want 2", bus.level); end
    @(negedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL async_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.level !== 3'd0) begin n_err++; $display("FAIL async_level: got %0d want 0", bus.level); end
    n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL async_pc: got %h want 0", bus.out_pc); end
    @(negedge clk);
    reset = 1'b1;
    idle();
  endtask

  task automatic test_random();
    logic v, rdy, fl;
    logic [31:0] instr, pc;
    for (int i = 0; i < 400; i++) begin
      v     = ($urandom_range(0, 3) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      fl    = ($urandom_range(0, 19) == 0);
      instr = $urandom;
      pc    = 32'h3000 + 4 * i;
      cycle(v, instr, pc, rdy, fl);
      n_cmp++; if (bus.level !== 3'(exp_q.size())) begin n_err++; $display("FAIL rand_level_%0d: got %0d want %0d", i, bus.level, exp_q.size()); end
      n_cmp++; if (bus.out_valid !== (exp_q.size() != 0)) begin n_err++; $display("FAIL rand_valid_%0d: got %b want %b", i, bus.out_valid, exp_q.size() != 0); end
      n_cmp++; if (bus.in_ready !== (exp_q.size() != DEPTH)) begin n_err++; $display("FAIL rand_in_ready_%0d: got %b want %b", i, bus.in_ready, exp_q.size() != DEPTH); end
      n_cmp++; if (bus.out_pc !== exp_pc()) begin n_err++; $display("FAIL rand_pc_%0d: got %h want %h", i, bus.out_pc, exp_pc()); end
      n_cmp++; if (bus.out_instr !== exp_instr()) begin n_err++; $display("FAIL rand_instr_%0d: got %h want %h", i, bus.out_instr, exp_instr()); end
    end
    drain();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_single_push();
    test_fill_full();
    test_stream_wrap();
    test_flush_collision();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
